// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent toggle dividers with per-channel enable and glitch-free runtime half-period reprogramming.
// Optional build macro CLKDIV_SYNC_EN adds sync_in to re-phase all enabled channels.
module multi_channel_clock_divider #(
  parameter int               NUM_CH       = 2,
  parameter int               CNT_W        = 12,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = 12'h018,
  parameter int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] ch_sel;
  logic              cfg_fire;
  logic              sync_req;

`ifdef CLKDIV_SYNC_EN
  assign sync_req = sync_in;
`else
  assign sync_req = 1'b0;
`endif

  // An out-of-range cfg_ch selects no channel, so it is always ready and dropped.
  assign cfg_ready = ~|(ch_sel & pending);
  assign cfg_fire  = cfg_valid & cfg_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] counter_reg;
    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] pending_half_reg;
    logic             clock_reg;
    logic             tick_reg;
    logic             pending_reg;
    logic             take_cfg;

    assign ch_sel[gi] = (cfg_ch == CH_W'(gi));
    assign take_cfg   = cfg_fire & ch_sel[gi];

    always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
        counter_reg      <= '0;
        half_reg         <= DEFAULT_HALF;
        pending_half_reg <= '0;
        clock_reg        <= 1'b0;
        tick_reg         <= 1'b0;
        pending_reg      <= 1'b0;
      end else begin
        tick_reg <= 1'b0;
        if (!enable[gi] || sync_req) begin
          counter_reg <= '0;
          clock_reg   <= 1'b0;
          if (pending_reg) begin
            half_reg    <= pending_half_reg;
            pending_reg <= 1'b0;
          end
        end else if (counter_reg == half_reg) begin
          counter_reg <= '0;
          clock_reg   <= ~clock_reg;
          tick_reg    <= 1'b1;
          // Only the rising edge is a period boundary; the new high phase uses the new value.
          if (!clock_reg && pending_reg) begin
            half_reg    <= pending_half_reg;
            pending_reg <= 1'b0;
          end
        end else begin
          counter_reg <= counter_reg + 1'b1;
        end

        // take_cfg implies pending_reg is clear, so this never collides with an apply above.
        if (take_cfg) begin
          if (enable[gi]) begin
            pending_half_reg <= cfg_half;
            pending_reg      <= 1'b1;
          end else begin
            half_reg <= cfg_half;
          end
        end
      end
    end

    assign clock_out[gi] = clock_reg;
    assign tick[gi]      = tick_reg;
    assign pending[gi]   = pending_reg;
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Scoreboard bench for multi_channel_clock_divider: expected toggle cycles/levels are queued when
// stimulus is driven and popped when tick fires. Define CLKDIV_SYNC_EN to also exercise sync_in.
module tb_multi_channel_clock_divider;

  typedef struct {
    int   cyc;
    logic lvl;
  } exp_t;

  logic        clock_in = 1'b0;
  logic        reset;
  logic [1:0]  enable;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [11:0] cfg_half;
  logic        cfg_ready;
  logic [1:0]  clock_out;
  logic [1:0]  tick;
  logic [1:0]  pending;
`ifdef CLKDIV_SYNC_EN
  logic        sync_in;
`endif

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t0;
  exp_t q0[$];
  exp_t q1[$];

  multi_channel_clock_divider #(
    .NUM_CH(2), .CNT_W(12), .DEFAULT_HALF(12'h018), .CH_W(2)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
`ifdef CLKDIV_SYNC_EN
    .sync_in  (sync_in),
`endif
    .clock_out(clock_out),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clock_in = ~clock_in;
  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end else begin
      $display("ok   %s @cyc %0d: 0x%0h", tag, cyc, obs);
    end
  endtask

  function automatic int q_size(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int ch);
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t q_pop(input int ch);
    if (ch == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Queue n toggles starting at cycle first, spaced per cycles, levels alternating from lvl.
  function automatic void push_run(input int ch, input int first, input int per, input int n,
                                   input logic lvl);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = first + k * per;
      e.lvl = lvl ^ k[0];
      if (ch == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endfunction

  always @(negedge clock_in) begin
    exp_t e;
    for (int ch = 0; ch < 2; ch++) begin
      while (q_size(ch) > 0 && q_front(ch).cyc < cyc) begin
        e = q_pop(ch);
        check_eq($sformatf("ch%0d_tick_missing", ch), cyc, e.cyc);
      end
      if (tick[ch]) begin
        if (q_size(ch) == 0) begin
          check_eq($sformatf("ch%0d_tick_unexpected", ch), 32'(tick[ch]), 0);
        end else begin
          e = q_pop(ch);
          check_eq($sformatf("ch%0d_tick_cyc", ch), cyc, e.cyc);
          check_eq($sformatf("ch%0d_tick_level", ch), 32'(clock_out[ch]), 32'(e.lvl));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    enable    = 2'b00;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_half  = 12'h000;
`ifdef CLKDIV_SYNC_EN
    sync_in   = 1'b0;
`endif
    repeat (3) step();
    check_eq("rst_clock_out", 32'(clock_out), 0);
    check_eq("rst_tick", 32'(tick), 0);
    check_eq("rst_pending", 32'(pending), 0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 1);
    reset = 1'b1;
    step();
    step();

    // Default /50 on channel 0.
    t0 = cyc;
    enable = 2'b01;
    push_run(0, t0 + 25, 25, 5, 1'b1);

    wait_cyc(t0 + 84);
    check_eq("ch1_idle", 32'(clock_out[1]), 0);
    check_eq("ready_before_cfg", 32'(cfg_ready), 1);

    // Reprogram ch0 mid high-phase; applies at the rising edge at t0+125.
    wait_cyc(t0 + 85);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 12'h004;
    wait_cyc(t0 + 86);
    cfg_valid = 1'b0;
    push_run(0, t0 + 130, 5, 7, 1'b0);
    #1;
    check_eq("pend_set", 32'(pending), 32'h1);
    check_eq("ready_blocked", 32'(cfg_ready), 0);
    wait_cyc(t0 + 124);
    check_eq("pend_hold", 32'(pending), 32'h1);
    wait_cyc(t0 + 125);
    check_eq("pend_clear_at_rise", 32'(pending), 0);

    // Direct write to disabled ch1, then f_clk/2.
    wait_cyc(t0 + 140);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 12'h000;
    #1;
    check_eq("ready_ch1", 32'(cfg_ready), 1);
    wait_cyc(t0 + 141);
    cfg_valid = 1'b0;
    #1;
    check_eq("pend_disabled_write", 32'(pending), 0);
    wait_cyc(t0 + 145);
    enable = 2'b11;
    push_run(1, t0 + 146, 1, 10, 1'b1);
    wait_cyc(t0 + 155);
    enable = 2'b01;

    // Drop enable with a pending value on ch0.
    wait_cyc(t0 + 160);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 12'h009;
    #1;
    check_eq("ready_ch0_again", 32'(cfg_ready), 1);
    wait_cyc(t0 + 161);
    cfg_valid = 1'b0;
    #1;
    check_eq("pend_set2", 32'(pending), 32'h1);
    check_eq("ch1_stopped_low", 32'(clock_out[1]), 0);
    wait_cyc(t0 + 162);
    enable = 2'b00;
    wait_cyc(t0 + 163);
    check_eq("pend_drop_apply", 32'(pending), 0);
    check_eq("clock_off", 32'(clock_out), 0);
    wait_cyc(t0 + 170);
    enable = 2'b01;
    push_run(0, t0 + 180, 10, 3, 1'b1);

    // Out-of-range channel: accepted and dropped.
    wait_cyc(t0 + 185);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 12'h001;
    #1;
    check_eq("ready_oob", 32'(cfg_ready), 1);
    wait_cyc(t0 + 186);
    cfg_valid = 1'b0;
    #1;
    check_eq("pend_oob", 32'(pending), 0);

    // Async reset while ch0 is high.
    wait_cyc(t0 + 205);
    reset = 1'b0;
    enable = 2'b00;
    #1;
    check_eq("mid_rst_clock_out", 32'(clock_out), 0);
    check_eq("mid_rst_tick", 32'(tick), 0);
    check_eq("mid_rst_pending", 32'(pending), 0);
    check_eq("mid_rst_ready", 32'(cfg_ready), 1);
    wait_cyc(t0 + 208);
    reset = 1'b1;
    wait_cyc(t0 + 210);
    enable = 2'b01;
    push_run(0, t0 + 235, 25, 2, 1'b1);
    wait_cyc(t0 + 265);
    check_eq("q0_drained", q_size(0), 0);
    check_eq("q1_drained", q_size(1), 0);

`ifdef CLKDIV_SYNC_EN
    enable = 2'b00;
    wait_cyc(t0 + 270);
    t0 = cyc;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 12'h009;
    wait_cyc(t0 + 1);
    cfg_valid = 1'b0;
    enable = 2'b01;
    push_run(0, t0 + 26, 25, 1, 1'b1);
    wait_cyc(t0 + 4);
    enable = 2'b11;
    push_run(1, t0 + 14, 10, 2, 1'b1);
    wait_cyc(t0 + 30);
    sync_in = 1'b1;
    push_run(1, t0 + 41, 10, 3, 1'b1);
    push_run(0, t0 + 56, 25, 1, 1'b1);
    wait_cyc(t0 + 31);
    sync_in = 1'b0;
    check_eq("sync_clock_low", 32'(clock_out), 0);
    wait_cyc(t0 + 66);
    check_eq("sync_q0_drained", q_size(0), 0);
    check_eq("sync_q1_drained", q_size(1), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the fixed single-output toggle divider.
- Generates NUM_CH independent square-wave clocks from clock_in, each with its own enable and runtime-programmable half-period.
- Reprogramming goes through a valid/ready config port and takes effect only at a period boundary, so no output glitches or runt pulses.
- Drives backscatter subcarrier/shift clocks (e.g. 2 MHz from 100 MHz) in the tag datapath.

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- CNT_W, 12, width of the per-channel counter and half-period value.
- DEFAULT_HALF, 12'h018, reset half-period value for every channel (toggle after DEFAULT_HALF+1 cycles; /50).
- CH_W, $clog2(NUM_CH) minimum 1, width of cfg_ch.

Ports:
- clock_in  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  NUM_CH  per-channel run enable, synchronous.
- cfg_valid  input  1  config request.
- cfg_ch  input  CH_W  target channel.
- cfg_half  input  CNT_W  new half-period value.
- cfg_ready  output  1  config accept.
- clock_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  1-cycle pulse on the cycle each clock_out toggles.
- pending  output  NUM_CH  channel holds an accepted, not-yet-applied half value.

Behaviour:
- Reset (async, reset=0):
  - All counters 0, half_reg = DEFAULT_HALF.
  - clock_out = 0, tick = 0, pending = 0, cfg_ready = 1.
- Per enabled channel, each clock_in edge:
  - If counter == half_reg: counter <= 0, clock_out toggles, tick = 1.
  - Else: counter <= counter+1, tick = 0.
  - Output frequency = f_clk / (2*(half_reg+1)); half_reg = 0 gives f_clk/2.
- Disabled channel (enable=0):
  - counter held at 0, clock_out forced 0 on next edge, tick = 0.
- Enable 0->1:
  - clock_out stays low for half_reg+1 cycles, then rises (first tick).
  - Phase is deterministic relative to the enable assertion.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] (combinational on cfg_ch); cfg_ch >= NUM_CH gives cfg_ready = 1.
  - Transfer occurs when cfg_valid & cfg_ready in the same cycle.
  - Transfer to an enabled channel: pending_half <= cfg_half, pending <= 1.
  - Transfer to a disabled channel: half_reg <= cfg_half directly, pending stays 0.
  - Transfer with cfg_ch >= NUM_CH: accepted and dropped, no state change.
- Apply rule:
  - A pending value is applied only on the toggle where clock_out goes 0->1 (period boundary): half_reg <= pending_half, pending <= 0 in that same cycle.
  - The high phase starting at that edge already uses the new value.
  - Every output period is made of two equal halves, old or new, never mixed.
- Enable dropped while pending=1: pending value is applied on the next cycle and pending clears.
- Simultaneous events:
  - Config on channel A while channel B applies: both take effect; channels are fully independent.
  - A second config to the same channel is back-pressured (cfg_ready=0) until apply.
- Async reset mid-period: outputs return to reset values immediately; pending writes are lost.
- Counter never exceeds half_reg, since half_reg changes only when counter returns to 0; no wrap-around case exists.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined: adds port sync_in (input, 1).
  - A 1-cycle pulse re-phases every enabled channel on the next edge: counter <= 0, clock_out <= 0, any pending value applied immediately, tick = 0.
  - Channels then behave as after a fresh enable, so all outputs are phase-aligned.
  - sync_in has priority over a same-cycle toggle.
- Not defined: no sync_in port, no re-phase logic; all other behaviour identical.

Test Plan:
- Reset release, enable=2'b01, defaults -> clock_out[0] first rises 25 cycles after enable, then toggles every 25 cycles (period 50); tick[0] pulses exactly at each toggle; clock_out[1] stays 0.
- Channel 0 running at 0x018; write cfg_half=0x004 mid high-phase -> pending[0]=1, cfg_ready=0 for ch0; current and next half keep 25 cycles; from the next rising edge the halves are 5 cycles; pending clears on that edge.
- Write cfg_half=0x000 to disabled channel 1, then enable -> pending never set; clock_out[1] toggles every cycle (f_clk/2) starting 1 cycle after enable.
- Drop enable[0] while pending=1 -> clock_out[0]=0 next cycle, pending[0] clears, half_reg updated; re-enable uses the new value.
- cfg_valid with cfg_ch=3 (NUM_CH=2) -> cfg_ready=1, no channel state changes; assert reset mid-period -> all outputs 0 immediately, half back to 0x018.
- CLKDIV_SYNC_EN build: channels at 0x018 and 0x009 with skewed phase, pulse sync_in -> both outputs 0 next cycle, then rise after 25 and 10 cycles respectively.
